branch_resolve: RTL and testbench

- Back end of the fetch-time pre-decode path.
- Takes the pre-decoded control-transfer flags and immediate for each fetched instruction and produces a static next-PC prediction.
- Records each control-transfer prediction in an in-order queue.
- When execute resolves that instruction, compares the outcome against the head entry and issues a registered redirect/flush on mispredict.
- Sits between the IF stage (prediction) and the EX stage (resolution).

---
 rtl/branch_resolve.sv | 185 ++++++++++++++++++
 tb/tb_branch_resolve.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: static next-PC prediction for fetched control-transfer
// instructions, an in-order queue of outstanding predictions, and a registered
// redirect/flush when execute resolves an instruction against a wrong guess.
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,

    // Fetch side
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    input  logic        inst_jal_i,
    input  logic        inst_jalr_i,
    input  logic        inst_bxx_i,
    input  logic [31:0] jb_imm_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_pc_o,
    output logic        stall_o,

    // Execute side
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        err_o,
    output logic [31:0] mispredict_cnt_o
);

    // One outstanding prediction, in fetch order.
    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } entry_t;

    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             redirect_q,       redirect_d;
    logic [31:0]      redirect_pc_q,    redirect_pc_d;
    logic             err_q,            err_d;
    logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic        cti;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        q_empty;
    logic        q_full;
    logic        pop;
    logic        push;
    logic        stall;
    logic        mispredict;
    logic [31:0] correct_pc;
    entry_t      head;
    entry_t      push_entry;

    assign head       = mem_q[rd_ptr_q];
    assign q_empty    = (count_q == '0);
    assign q_full     = (count_q == FULL_CNT);
    assign push_entry = '{pc: if_pc_i, pred_taken: pred_taken, pred_pc: pred_pc};

    // Static prediction: JAL always taken, backward conditional branches taken,
    // JALR (target unknown at fetch) and non-CTIs fall through.
    always_comb begin
        cti        = if_valid_i & (inst_jal_i | inst_jalr_i | inst_bxx_i);
        pred_taken = cti & (inst_jal_i | (inst_bxx_i & jb_imm_i[31]));
        pred_pc    = pred_taken ? (if_pc_i + jb_imm_i) : (if_pc_i + 32'd4);
    end

    // Resolve the head entry against the execute outcome and arbitrate push/pop.
    always_comb begin
        pop        = ex_valid_i & ~q_empty;
        correct_pc = ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4);
        mispredict = pop & ((ex_taken_i != head.pred_taken) |
                            (ex_taken_i & (ex_target_i != head.pred_pc)));
        // A full queue can still take a new entry when the head leaves this cycle.
        stall      = cti & q_full & ~pop;
        // On a mispredict the fetched instruction is on the wrong path: drop it.
        push       = cti & ~stall & ~mispredict;
    end

    // Next-state for queue pointers, occupancy and the registered outputs.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        redirect_d       = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        err_d            = err_q;

        if (mispredict) begin
            // Flush: everything younger than the resolving instruction is wrong-path.
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
            redirect_d       = 1'b1;
            redirect_pc_d    = correct_pc;
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Protocol errors: resolving with nothing outstanding, or out of order.
        if (ex_valid_i & q_empty) begin
            err_d = 1'b1;
        end
        if (pop & (ex_pc_i != head.pc)) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Control and output registers, cleared by the asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments only; the _d values
    // are settled in always_comb so every flop samples a consistent snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            redirect_q       <= 1'b0;
            redirect_pc_q    <= '0;
            err_q            <= 1'b0;
            mispredict_cnt_q <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            redirect_q       <= redirect_d;
            redirect_pc_q    <= redirect_pc_d;
            err_q            <= err_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Queue storage written at the tail on each accepted push.
    // NOTE: the entry array is deliberately not reset; an entry is only read
    // when count_q says it is valid, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pred_taken_o     = pred_taken;
    assign pred_pc_o        = pred_pc;
    assign stall_o          = stall;
    assign redirect_o       = redirect_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign err_o            = err_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_branch_resolve;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic        inst_jal_i = 1'b0;
    logic        inst_jalr_i = 1'b0;
    logic        inst_bxx_i = 1'b0;
    logic [31:0] jb_imm_i = '0;
    logic        pred_taken_o;
    logic [31:0] pred_pc_o;
    logic        stall_o;
    logic        ex_valid_i = 1'b0;
    logic [31:0] ex_pc_i = '0;
    logic        ex_taken_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        err_o;
    logic [31:0] mispredict_cnt_o;

    branch_resolve #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_valid_i       (if_valid_i),
        .if_pc_i          (if_pc_i),
        .inst_jal_i       (inst_jal_i),
        .inst_jalr_i      (inst_jalr_i),
        .inst_bxx_i       (inst_bxx_i),
        .jb_imm_i         (jb_imm_i),
        .pred_taken_o     (pred_taken_o),
        .pred_pc_o        (pred_pc_o),
        .stall_o          (stall_o),
        .ex_valid_i       (ex_valid_i),
        .ex_pc_i          (ex_pc_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .err_o            (err_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_t;

    pred_t       model_q[$];
    logic        m_redirect;
    logic [31:0] m_redirect_pc;
    logic        m_err;
    logic [31:0] m_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        m_redirect    = 1'b0;
        m_redirect_pc = '0;
        m_err         = 1'b0;
        m_cnt         = '0;
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc, input int kind, input logic [31:0] imm);
        // kind: 0 none, 1 JAL, 2 JALR, 3 branch
        if_valid_i  = v;
        if_pc_i     = pc;
        inst_jal_i  = (kind == 1);
        inst_jalr_i = (kind == 2);
        inst_bxx_i  = (kind == 3);
        jb_imm_i    = imm;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        ex_valid_i  = v;
        ex_pc_i     = pc;
        ex_taken_i  = tk;
        ex_target_i = tgt;
    endtask

    task automatic idle_inputs();
        set_fetch(1'b0, 32'h0, 0, 32'h0);
        set_ex(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check registered outputs just after the edge. Called at posedge+1.
    task automatic cycle();
        logic        cti, ptaken, pop, stall, mis;
        logic [31:0] ppc, cpc;
        pred_t       h;
        pred_t       e;
        @(negedge clk);
        cti    = if_valid_i && (inst_jal_i || inst_jalr_i || inst_bxx_i);
        ptaken = cti && (inst_jal_i || (inst_bxx_i && jb_imm_i[31]));
        ppc    = ptaken ? if_pc_i + jb_imm_i : if_pc_i + 32'd4;
        pop    = ex_valid_i && (model_q.size() != 0);
        stall  = cti && (model_q.size() == DEPTH) && !pop;
        check("pred_taken", {31'b0, pred_taken_o}, {31'b0, ptaken});
        check("pred_pc", pred_pc_o, ppc);
        check("stall", {31'b0, stall_o}, {31'b0, stall});

        mis = 1'b0;
        cpc = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
        if (ex_valid_i) begin
            if (model_q.size() == 0) begin
                m_err = 1'b1;
            end else begin
                h = model_q.pop_front();
                if (ex_pc_i != h.pc) m_err = 1'b1;
                mis = (ex_taken_i != h.taken) || (ex_taken_i && ex_target_i != h.target);
            end
        end
        m_redirect = mis;
        if (mis) begin
            model_q.delete();
            m_redirect_pc = cpc;
            m_cnt         = m_cnt + 1;
        end else if (cti && !stall) begin
            e.pc = if_pc_i; e.taken = ptaken; e.target = ppc;
            model_q.push_back(e);
        end

        @(posedge clk);
        #1;
        check("redirect", {31'b0, redirect_o}, {31'b0, m_redirect});
        check("redirect_pc", redirect_pc_o, m_redirect_pc);
        check("err", {31'b0, err_o}, {31'b0, m_err});
        check("mispredict_cnt", mispredict_cnt_o, m_cnt);
    endtask

    // Asynchronous reset pulse away from the clock edge; called at posedge+1.
    task automatic pulse_reset(input logic with_cti);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_redirect", {31'b0, redirect_o}, 32'h0);
        check("rst_redirect_pc", redirect_pc_o, 32'h0);
        check("rst_err", {31'b0, err_o}, 32'h0);
        check("rst_cnt", mispredict_cnt_o, 32'h0);
        if (with_cti) begin
            // Combinational prediction still follows inputs; stall is 0 (queue empty).
            set_fetch(1'b1, 32'h500, 1, 32'h40);
            #1;
            check("rst_pred_pc", pred_pc_o, 32'h540);
            check("rst_stall", {31'b0, stall_o}, 32'h0);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        check("rst_hold_redirect", {31'b0, redirect_o}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        int          kind;
        int          off;
        logic [31:0] rpc;
        pred_t       h;

        model_clear();
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("init_redirect", {31'b0, redirect_o}, 32'h0);
        check("init_err", {31'b0, err_o}, 32'h0);
        rst = 1'b0;

        // JAL predicted taken, resolved correctly
        set_fetch(1'b1, 32'h100, 1, 32'h20); cycle();
        set_fetch(1'b0, 32'h0, 0, 32'h0);
        set_ex(1'b1, 32'h100, 1'b1, 32'h120); cycle();
        idle_inputs(); cycle();

        // Backward branch predicted taken, actually not taken
        set_fetch(1'b1, 32'h200, 3, 32'hFFFF_FFF0); cycle();
        set_fetch(1'b0, 32'h0, 0, 32'h0);
        set_ex(1'b1, 32'h200, 1'b0, 32'h0); cycle();
        idle_inputs(); cycle();

        // JALR predicted fall-through, actually taken
        set_fetch(1'b1, 32'h300, 2, 32'h0); cycle();
        set_fetch(1'b0, 32'h0, 0, 32'h0);
        set_ex(1'b1, 32'h300, 1'b1, 32'h80); cycle();
        idle_inputs(); cycle();

        // Fill the queue with forward branches, then present a fifth
        for (int i = 0; i < DEPTH; i++) begin
            set_fetch(1'b1, 32'h400 + 32'(i * 4), 3, 32'h10); cycle();
        end
        set_fetch(1'b1, 32'h410, 3, 32'h10); cycle();
        cycle();
        set_ex(1'b1, 32'h400, 1'b0, 32'h0); cycle();

        // Mispredict on head with a same-cycle fetch: push is dropped
        set_fetch(1'b1, 32'h414, 1, 32'h100);
        set_ex(1'b1, 32'h404, 1'b1, 32'h999C); cycle();
        idle_inputs(); cycle();

        // Resolve on an empty queue: sticky error
        set_ex(1'b1, 32'h700, 1'b0, 32'h0); cycle();
        idle_inputs(); cycle(); cycle();

        // Reset with three entries outstanding
        for (int i = 0; i < 3; i++) begin
            set_fetch(1'b1, 32'h600 + 32'(i * 4), 3, 32'h8); cycle();
        end
        pulse_reset(1'b1);
        idle_inputs(); cycle();
        set_ex(1'b1, 32'h600, 1'b0, 32'h0); cycle();
        idle_inputs(); cycle();
        pulse_reset(1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 600 == 599) pulse_reset(1'b0);
            kind = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3));
            off  = int'($urandom_range(0, 511)) - 256;
            set_fetch($urandom_range(0, 4) != 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                      kind, 32'(off * 4));
            if (model_q.size() != 0 && $urandom_range(0, 2) != 0) begin
                h   = model_q[0];
                rpc = ($urandom_range(0, 19) == 0) ? $urandom() : h.pc;
                if ($urandom_range(0, 3) != 0) begin
                    set_ex(1'b1, rpc, h.taken,
                           ($urandom_range(0, 4) != 0) ? h.target : $urandom());
                end else begin
                    set_ex(1'b1, rpc, ~h.taken, $urandom());
                end
            end else begin
                set_ex($urandom_range(0, 39) == 0, $urandom(), 1'($urandom()), $urandom());
            end
            cycle();
        end

        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
